// File: rtl/spike_dec_pkg.sv
// Shared constants and saturating-arithmetic helpers for the spike rate decoder.
package spike_dec_pkg;

  localparam int CNT_W    = 8;
  localparam int WIN_W    = 16;
  localparam int WIN_BASE = 8;

  localparam logic [CNT_W-1:0] SAT_MAX = {CNT_W{1'b1}};

  // Adds inc to val and clamps at max_val. Values travel as 32-bit
  // quantities so any counter width up to 31 bits can share this helper.
  function automatic logic [31:0] sat_add(input logic [31:0] val,
                                          input logic [31:0] inc,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, val} + {1'b0, inc};
    return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
  endfunction

  // All-ones value of a w-bit field, returned as a 32-bit quantity.
  function automatic logic [31:0] max_of(input int w);
    return 32'((64'd1 << w) - 64'd1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with clear, load-to-one and enable controls.
module sat_counter #(
  parameter int W = spike_dec_pkg::CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load_one,
  input  logic         en,
  input  logic         inc,
  output logic [W-1:0] count
);

  import spike_dec_pkg::*;

  localparam logic [31:0] MAX = max_of(W);

  // Clear beats load, load beats counting; the count holds while disabled
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      count <= '0;
    end else if (load_one) begin
      count <= W'(1);
    end else if (en) begin
      count <= W'(sat_add(32'(count), 32'(inc), MAX));
    end
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// Decodes a neuron spike line into a windowed firing rate and an
// inter-spike interval, each published with a one-cycle valid strobe.
module spike_rate_decoder #(
  parameter int CNT_W    = spike_dec_pkg::CNT_W,
  parameter int WIN_W    = spike_dec_pkg::WIN_W,
  parameter int WIN_BASE = spike_dec_pkg::WIN_BASE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             spike_in,
  input  logic [2:0]       win_sel,
  output logic [CNT_W-1:0] rate,
  output logic             rate_valid,
  output logic             rate_sat,
  output logic [CNT_W-1:0] isi,
  output logic             isi_valid
);

  import spike_dec_pkg::*;

  localparam logic [31:0] CNT_MAX = max_of(CNT_W);

  logic             spike_prev;
  logic             spk_edge;
  logic             win_end;
  logic             spk_full;
  logic             spk_ovf;
  logic             have_first;
  logic [2:0]       win_len_sel;
  logic [WIN_W-1:0] win_cnt;
  logic [WIN_W-1:0] win_last;
  logic [CNT_W-1:0] spk_cnt;
  logic [CNT_W-1:0] isi_cnt;

  // An edge only counts on enabled cycles; a held-high level counts once
  assign spk_edge = spike_in & ~spike_prev & ena;
  assign win_last = WIN_W'(max_of(WIN_BASE + int'(win_len_sel)));
  assign win_end  = ena & (win_cnt == win_last);
  assign spk_full = (32'(spk_cnt) == CNT_MAX);

  // Spike history follows the line even when disabled, so re-enabling
  // during a high level does not look like a fresh rising edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spike_prev <= 1'b0;
    end else begin
      spike_prev <= spike_in;
    end
  end

  sat_counter #(.W(CNT_W)) u_spk_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (win_end),
    .load_one (1'b0),
    .en       (ena),
    .inc      (spk_edge),
    .count    (spk_cnt)
  );

  sat_counter #(.W(CNT_W)) u_isi_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (1'b0),
    .load_one (spk_edge),
    .en       (ena & have_first),
    .inc      (1'b1),
    .count    (isi_cnt)
  );

  // Window timing and rate publication; spk_ovf remembers that the edge
  // count clipped earlier in the window, since the clipped count alone
  // cannot show it by the time the window closes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_cnt     <= '0;
      win_len_sel <= win_sel;
      spk_ovf     <= 1'b0;
      rate        <= '0;
      rate_sat    <= 1'b0;
      rate_valid  <= 1'b0;
    end else if (ena) begin
      if (win_end) begin
        win_cnt     <= '0;
        win_len_sel <= win_sel;
        spk_ovf     <= 1'b0;
        rate        <= CNT_W'(sat_add(32'(spk_cnt), 32'(spk_edge), CNT_MAX));
        rate_sat    <= spk_ovf | (spk_full & spk_edge);
        rate_valid  <= 1'b1;
      end else begin
        win_cnt     <= win_cnt + WIN_W'(1);
        spk_ovf     <= spk_ovf | (spk_full & spk_edge);
        rate_valid  <= 1'b0;
      end
    end else begin
      rate_valid <= 1'b0;
    end
  end

  // Interval publication; the first edge after reset only arms the measurement
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      have_first <= 1'b0;
      isi        <= '0;
      isi_valid  <= 1'b0;
    end else if (spk_edge) begin
      if (have_first) begin
        isi       <= isi_cnt;
        isi_valid <= 1'b1;
      end else begin
        isi_valid <= 1'b0;
      end
      have_first <= 1'b1;
    end else begin
      isi_valid <= 1'b0;
    end
  end

endmodule
